// File: rtl/mips_cpu_harvard_run_ctrl_if.sv
// Control/status bundle between the run controller and its harness.
// The master side is the controller; the slave side is the harness or bench.
interface mips_cpu_harvard_run_ctrl_if;
  logic        start;
  logic        abort;
  logic        cpu_active;
  logic [31:0] cpu_register_v0;
  logic        cpu_reset;
  logic        cpu_clk_enable;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        no_start;
  logic [31:0] result;
  logic [31:0] cycle_count;

  modport master (
    input  start, abort, cpu_active, cpu_register_v0,
    output cpu_reset, cpu_clk_enable, busy, done, timeout, no_start, result, cycle_count
  );

  modport slave (
    output start, abort, cpu_active, cpu_register_v0,
    input  cpu_reset, cpu_clk_enable, busy, done, timeout, no_start, result, cycle_count
  );
endinterface

// File: rtl/mips_cpu_harvard_run_ctrl.sv
// Run controller for mips_cpu_harvard: drives CPU reset/clock enable, times the run,
// and captures register_v0 on halt or timeout.
module mips_cpu_harvard_run_ctrl #(
  parameter int TIMEOUT_CYCLES = 100,
  parameter int RESET_CYCLES   = 1,
  parameter int ACTIVE_WAIT    = 4
) (
  input logic clk,
  input logic reset,
  mips_cpu_harvard_run_ctrl_if.master bus
);

  localparam int PMAX = (RESET_CYCLES > ACTIVE_WAIT) ? RESET_CYCLES : ACTIVE_WAIT;
  localparam int PW   = $clog2(PMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_WAIT, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] ph_cnt, ph_cnt_nx;
  logic [31:0]   count_q, count_nx;
  logic [31:0]   result_q, result_nx;
  logic          timeout_q, timeout_nx;
  logic          no_start_q, no_start_nx;
  logic          cpu_reset_q, cpu_reset_nx;
  logic          clk_en_q, clk_en_nx;
  logic          busy_q, busy_nx;
  logic          done_q, done_nx;

  always_comb begin
    state_nx    = state;
    ph_cnt_nx   = ph_cnt;
    count_nx    = count_q;
    result_nx   = result_q;
    timeout_nx  = timeout_q;
    no_start_nx = no_start_q;

    if (bus.abort) begin
      // result and cycle_count stay visible after an abort
      state_nx    = S_IDLE;
      timeout_nx  = 1'b0;
      no_start_nx = 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_nx    = S_RESET;
            ph_cnt_nx   = '0;
            count_nx    = '0;
            result_nx   = '0;
            timeout_nx  = 1'b0;
            no_start_nx = 1'b0;
          end
        end
        S_RESET: begin
          if (ph_cnt == PW'(RESET_CYCLES - 1)) begin
            state_nx  = S_WAIT;
            ph_cnt_nx = '0;
          end else begin
            ph_cnt_nx = ph_cnt + PW'(1);
          end
        end
        S_WAIT: begin
          if (bus.cpu_active) begin
            state_nx = S_RUN;
          end else if (ph_cnt == PW'(ACTIVE_WAIT - 1)) begin
            state_nx    = S_DONE;
            no_start_nx = 1'b1;
          end else begin
            ph_cnt_nx = ph_cnt + PW'(1);
          end
        end
        S_RUN: begin
          // a halt seen on the limit cycle still counts as a normal halt
          if (!bus.cpu_active) begin
            state_nx = S_DRAIN;
          end else if (count_q == 32'(TIMEOUT_CYCLES - 1)) begin
            state_nx   = S_DONE;
            timeout_nx = 1'b1;
            result_nx  = bus.cpu_register_v0;
          end else begin
            count_nx = count_q + 32'd1;
          end
        end
        S_DRAIN: begin
          state_nx  = S_DONE;
          result_nx = bus.cpu_register_v0;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Output flops are loaded from the decode of the next state.
  always_comb begin
    cpu_reset_nx = 1'b0;
    clk_en_nx    = 1'b1;
    busy_nx      = 1'b1;
    done_nx      = 1'b0;
    unique case (state_nx)
      S_IDLE:  begin cpu_reset_nx = 1'b1; clk_en_nx = 1'b0; busy_nx = 1'b0; end
      S_RESET: cpu_reset_nx = 1'b1;
      S_DONE:  begin clk_en_nx = 1'b0; busy_nx = 1'b0; done_nx = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      ph_cnt      <= '0;
      count_q     <= '0;
      result_q    <= '0;
      timeout_q   <= 1'b0;
      no_start_q  <= 1'b0;
      cpu_reset_q <= 1'b1;
      clk_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nx;
      ph_cnt      <= ph_cnt_nx;
      count_q     <= count_nx;
      result_q    <= result_nx;
      timeout_q   <= timeout_nx;
      no_start_q  <= no_start_nx;
      cpu_reset_q <= cpu_reset_nx;
      clk_en_q    <= clk_en_nx;
      busy_q      <= busy_nx;
      done_q      <= done_nx;
    end
  end

  assign bus.cpu_reset      = cpu_reset_q;
  assign bus.cpu_clk_enable = clk_en_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.timeout        = timeout_q;
  assign bus.no_start       = no_start_q;
  assign bus.result         = result_q;
  assign bus.cycle_count    = count_q;

endmodule

// File: tb/tb_mips_cpu_harvard_run_ctrl.sv
// Bench for mips_cpu_harvard_run_ctrl: a toy CPU plus a per-run expected-output timeline
// built from the run rules, compared every cycle on the falling edge.
module tb_mips_cpu_harvard_run_ctrl;
  localparam int TO = 100;
  localparam int RC = 1;
  localparam int AW = 4;

  localparam int P_IDLE = 0, P_RESET = 1, P_WAIT = 2, P_RUN = 3, P_DRAIN = 4, P_DONE = 5;

  typedef struct {
    logic        cr, en, busy, done, to, ns;
    logic [31:0] res, cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_cpu_harvard_run_ctrl_if bus ();

  mips_cpu_harvard_run_ctrl #(.TIMEOUT_CYCLES(TO), .RESET_CYCLES(RC), .ACTIVE_WAIT(AW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Toy CPU: raises active on its first enabled cycle out of reset, keeps it high so the
  // controller sees 'hold' active RUN cycles, then drops it.
  bit          rise_cfg;
  int          hold_cfg;
  logic [31:0] v0_cfg;
  int          cpu_n = 0;
  assign bus.cpu_register_v0 = v0_cfg;
  always @(posedge clk) begin
    if (reset) bus.cpu_active <= 1'b0;
    else if (bus.cpu_clk_enable) begin
      if (bus.cpu_reset) begin
        cpu_n          <= 0;
        bus.cpu_active <= 1'b0;
      end else begin
        cpu_n          <= cpu_n + 1;
        bus.cpu_active <= rise_cfg && (cpu_n + 1 <= hold_cfg + 1);
      end
    end
  end

  int   n_chk = 0, n_pass = 0, n_fail = 0;
  bit   chk_en = 0;
  exp_t cur_exp;
  exp_t tl[$];
  int   ab_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end else n_pass++;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cpu_reset",      32'(bus.cpu_reset),      32'(cur_exp.cr));
      chk("cpu_clk_enable", 32'(bus.cpu_clk_enable), 32'(cur_exp.en));
      chk("busy",           32'(bus.busy),           32'(cur_exp.busy));
      chk("done",           32'(bus.done),           32'(cur_exp.done));
      chk("timeout",        32'(bus.timeout),        32'(cur_exp.to));
      chk("no_start",       32'(bus.no_start),       32'(cur_exp.ns));
      chk("result",         bus.result,              cur_exp.res);
      chk("cycle_count",    bus.cycle_count,         cur_exp.cnt);
    end
  end

  function automatic exp_t mk(int ph, int cnt, logic [31:0] res, bit to, bit ns);
    exp_t e;
    e.cr   = (ph == P_IDLE) || (ph == P_RESET);
    e.en   = (ph != P_IDLE) && (ph != P_DONE);
    e.busy = e.en;
    e.done = (ph == P_DONE);
    e.to   = to;
    e.ns   = ns;
    e.res  = res;
    e.cnt  = 32'(cnt);
    return e;
  endfunction

  // Expected outputs for each cycle after the start edge. The toy CPU rises one cycle
  // after reset release, so an active run spends two cycles waiting.
  task automatic build(input bit rise, input int hold, input int abort_at, input logic [31:0] v0);
    tl.delete();
    ab_idx = -1;
    for (int i = 0; i < RC; i++) tl.push_back(mk(P_RESET, 0, 0, 0, 0));
    if (!rise) begin
      for (int i = 0; i < AW; i++) tl.push_back(mk(P_WAIT, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++)  tl.push_back(mk(P_DONE, 0, 0, 0, 1));
    end else begin
      for (int i = 0; i < 2; i++) tl.push_back(mk(P_WAIT, 0, 0, 0, 0));
      if (abort_at >= 0) begin
        for (int i = 0; i <= abort_at; i++) tl.push_back(mk(P_RUN, i, 0, 0, 0));
        ab_idx = tl.size() - 1;
        for (int i = 0; i < 3; i++) tl.push_back(mk(P_IDLE, abort_at, 0, 0, 0));
      end else if (hold <= TO - 1) begin
        for (int i = 0; i <= hold; i++) tl.push_back(mk(P_RUN, i, 0, 0, 0));
        tl.push_back(mk(P_DRAIN, hold, 0, 0, 0));
        for (int i = 0; i < 3; i++) tl.push_back(mk(P_DONE, hold, v0, 0, 0));
      end else begin
        for (int i = 0; i < TO; i++) tl.push_back(mk(P_RUN, i, 0, 0, 0));
        for (int i = 0; i < 3; i++) tl.push_back(mk(P_DONE, TO - 1, v0, 1, 0));
      end
    end
  endtask

  task automatic run_tl(input int abort_idx, input int start_idx, input int n_max);
    for (int j = 0; j < tl.size() && j < n_max; j++) begin
      @(posedge clk); #1;
      cur_exp   = tl[j];
      bus.start = (j == start_idx);
      bus.abort = (j == abort_idx);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
    end
  endtask

  task automatic launch(input bit rise, input int hold, input int abort_at, input logic [31:0] v0);
    rise_cfg = rise; hold_cfg = hold; v0_cfg = v0;
    build(rise, hold, abort_at, v0);
    bus.start = 1'b1;
  endtask

  initial begin
    reset = 1'b1; bus.start = 1'b0; bus.abort = 1'b0;
    rise_cfg = 0; hold_cfg = 0; v0_cfg = 32'h0;
    cur_exp = mk(P_IDLE, 0, 0, 0, 0);
    @(posedge clk); #1 chk_en = 1;
    @(posedge clk); #1 reset = 1'b0;
    idle_cycles(2);

    // 1: normal halt after 10 RUN cycles
    launch(1, 10, -1, 32'h2A); run_tl(-1, -1, 1000); idle_cycles(3);
    chk("t1_result", bus.result, 32'h2A);
    chk("t1_count",  bus.cycle_count, 32'd10);
    chk("t1_timeout", 32'(bus.timeout), 32'd0);

    // 6: restart from DONE reproduces run 1
    launch(1, 10, -1, 32'h2A); run_tl(-1, -1, 1000);
    chk("t6_done",  32'(bus.done), 32'd1);
    chk("t6_count", bus.cycle_count, 32'd10);

    // 5: halt on the limit cycle wins over timeout; a start mid-run is ignored
    launch(1, 99, -1, 32'h1234); run_tl(-1, 20, 1000);
    chk("t5_timeout", 32'(bus.timeout), 32'd0);
    chk("t5_count",   bus.cycle_count, 32'd99);

    // abort together with start in DONE: abort wins, result/count retained
    bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1;
    cur_exp = mk(P_IDLE, 99, 32'h1234, 0, 0);
    bus.start = 1'b0; bus.abort = 1'b0;
    idle_cycles(2);

    // 2: active never falls -> timeout
    launch(1, 1000, -1, 32'hDEADBEEF); run_tl(-1, -1, 1000);
    chk("t2_timeout", 32'(bus.timeout), 32'd1);
    chk("t2_count",   bus.cycle_count, 32'd99);
    chk("t2_clk_en",  32'(bus.cpu_clk_enable), 32'd0);

    // 3: active never rises -> no_start
    launch(0, 0, -1, 32'h55); run_tl(-1, -1, 1000);
    chk("t3_no_start", 32'(bus.no_start), 32'd1);
    chk("t3_result",   bus.result, 32'd0);
    chk("t3_count",    bus.cycle_count, 32'd0);

    // 4: abort while cycle_count is 5
    launch(1, 1000, 5, 32'h77); run_tl(ab_idx, -1, 1000);
    chk("t4_count",     bus.cycle_count, 32'd5);
    chk("t4_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    chk("t4_done",      32'(bus.done), 32'd0);

    // controller reset in the middle of RUN
    launch(1, 1000, -1, 32'h99); run_tl(-1, -1, 8);
    reset = 1'b1;
    @(posedge clk); #1;
    cur_exp = mk(P_IDLE, 0, 0, 0, 0);
    reset = 1'b0;
    idle_cycles(3);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
